// File: rtl/rom_dl_router.sv
// ROM download router: steers ioctl index-0 bytes to SDRAM port1/port2 or BRAM using
// ack-checked toggle handshakes, with backpressure, ack timeout and a sticky rom_loaded flag.
module rom_dl_router #(
  parameter logic [24:0] CPU_END  = 25'h0009FFF,
  parameter logic [24:0] SP_BASE  = 25'h0010000,
  parameter logic [24:0] SP_END   = 25'h001BFFF,
  parameter logic [24:0] BRAM_END = 25'h001C31F,
  parameter logic [24:0] ROM_SIZE = 25'h001C320,
  parameter logic [7:0]  ACK_TMO  = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic [22:0] p1_a,
  output logic [1:0]  p1_ds,
  output logic [15:0] p1_d,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic [22:0] p2_a,
  output logic [1:0]  p2_ds,
  output logic [15:0] p2_d,
  output logic        bram_wr,
  output logic [16:0] bram_addr,
  output logic [7:0]  bram_d,
  output logic        rom_loaded,
  output logic        dl_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DST_P1   = 2'd0,
    DST_P2   = 2'd1,
    DST_BRAM = 2'd2,
    DST_DROP = 2'd3
  } dest_t;

  function automatic dest_t decode_dest(input logic [24:0] a);
    dest_t d;
    if (a <= CPU_END) begin
      d = DST_P1;
    end else if ((a >= SP_BASE) && (a <= SP_END)) begin
      d = DST_P2;
    end else if (a <= BRAM_END) begin
      d = DST_BRAM;
    end else begin
      d = DST_DROP;
    end
    return d;
  endfunction

  state_t      state_r, state_next_s;
  logic        wr_last_r, dl_last_r;
  logic [24:0] cur_addr_r, pend_addr_r;
  logic [7:0]  cur_data_r, pend_data_r;
  logic        pend_vld_r;
  logic        p1_req_r, p2_req_r;
  logic [22:0] p1_a_r, p2_a_r;
  logic [1:0]  p1_ds_r, p2_ds_r;
  logic [15:0] p1_d_r, p2_d_r;
  logic        bram_wr_r;
  logic [16:0] bram_addr_r;
  logic [7:0]  bram_d_r;
  logic [7:0]  tmo_r;
  logic [24:0] count_r;
  logic        loaded_r, arm_r, err_r;

  logic        wr_rise_s, dl_rise_s, dl_fall_s, take_s, idle_s, lost_s, quiet_s;
  logic        ack_match_s, tmo_err_s;
  dest_t       cur_dest_s;
  logic [23:0] p2_off_s;

  assign wr_rise_s   = ioctl_wr & ~wr_last_r;
  assign dl_rise_s   = ioctl_download & ~dl_last_r;
  assign dl_fall_s   = ~ioctl_download & dl_last_r;
  assign take_s      = reset_n & ioctl_download & (ioctl_index == 8'd0) & wr_rise_s;
  assign idle_s      = (state_r == ST_IDLE);
  assign lost_s      = take_s & ~idle_s & pend_vld_r;
  assign quiet_s     = idle_s & ~pend_vld_r;
  assign cur_dest_s  = decode_dest(cur_addr_r);
  assign p2_off_s    = cur_addr_r[23:0] - SP_BASE[23:0];
  assign ack_match_s = (cur_dest_s == DST_P2) ? (p2_ack == p2_req_r) : (p1_ack == p1_req_r);
  assign tmo_err_s   = (state_r == ST_WAIT_ACK) & ~ack_match_s & (tmo_r == 8'd0);

  // Backpressure rises combinationally on the accept cycle so hps_io stalls at once
  assign ioctl_wait = reset_n & (~idle_s | pend_vld_r | take_s);

  assign p1_req     = p1_req_r;
  assign p1_a       = p1_a_r;
  assign p1_ds      = p1_ds_r;
  assign p1_d       = p1_d_r;
  assign p2_req     = p2_req_r;
  assign p2_a       = p2_a_r;
  assign p2_ds      = p2_ds_r;
  assign p2_d       = p2_d_r;
  assign bram_wr    = bram_wr_r;
  assign bram_addr  = bram_addr_r;
  assign bram_d     = bram_d_r;
  assign rom_loaded = loaded_r;
  assign dl_err     = err_r;

  // Edge detectors for the write strobe and the download flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_last_r <= 1'b0;
      dl_last_r <= 1'b0;
    end else begin
      wr_last_r <= ioctl_wr;
      dl_last_r <= ioctl_download;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pend_vld_r || take_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((cur_dest_s == DST_P1) || (cur_dest_s == DST_P2)) begin
          state_next_s = ST_WAIT_ACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_match_s || (tmo_r == 8'd0)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Current-byte latch plus 1-deep pending slot; a waiting byte always wins over a new edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_addr_r  <= 25'd0;
      cur_data_r  <= 8'd0;
      pend_addr_r <= 25'd0;
      pend_data_r <= 8'd0;
      pend_vld_r  <= 1'b0;
    end else if (idle_s) begin
      if (pend_vld_r) begin
        cur_addr_r <= pend_addr_r;
        cur_data_r <= pend_data_r;
        if (take_s) begin
          pend_addr_r <= ioctl_addr;
          pend_data_r <= ioctl_dout;
        end else begin
          pend_vld_r <= 1'b0;
        end
      end else if (take_s) begin
        cur_addr_r <= ioctl_addr;
        cur_data_r <= ioctl_dout;
      end
    end else if (take_s && !pend_vld_r) begin
      pend_addr_r <= ioctl_addr;
      pend_data_r <= ioctl_dout;
      pend_vld_r  <= 1'b1;
    end
  end

  // Port outputs load only in ISSUE, so they stay stable from req toggle until ack
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p1_req_r    <= 1'b0;
      p1_a_r      <= 23'd0;
      p1_ds_r     <= 2'd0;
      p1_d_r      <= 16'd0;
      p2_req_r    <= 1'b0;
      p2_a_r      <= 23'd0;
      p2_ds_r     <= 2'd0;
      p2_d_r      <= 16'd0;
      bram_wr_r   <= 1'b0;
      bram_addr_r <= 17'd0;
      bram_d_r    <= 8'd0;
    end else begin
      bram_wr_r <= 1'b0;
      if (state_r == ST_ISSUE) begin
        case (cur_dest_s)
          DST_P1: begin
            p1_req_r <= ~p1_req_r;
            p1_a_r   <= cur_addr_r[23:1];
            p1_ds_r  <= {cur_addr_r[0], ~cur_addr_r[0]};
            p1_d_r   <= {cur_data_r, cur_data_r};
          end
          DST_P2: begin
            // Sprite bytes are interleaved into 32-bit words on the SDRAM side
            p2_req_r <= ~p2_req_r;
            p2_a_r   <= {p2_off_s[23:16], p2_off_s[13:0], p2_off_s[15]};
            p2_ds_r  <= {p2_off_s[14], ~p2_off_s[14]};
            p2_d_r   <= {cur_data_r, cur_data_r};
          end
          DST_BRAM: begin
            bram_wr_r   <= 1'b1;
            bram_addr_r <= cur_addr_r[16:0];
            bram_d_r    <= cur_data_r;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Ack timeout counter and sticky error flag (cleared when a new download starts)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_r <= 8'd0;
      err_r <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) begin
        tmo_r <= ACK_TMO;
      end else if ((state_r == ST_WAIT_ACK) && !ack_match_s && (tmo_r != 8'd0)) begin
        tmo_r <= tmo_r - 8'd1;
      end
      if (tmo_err_s || lost_s) begin
        err_r <= 1'b1;
      end else if (dl_rise_s) begin
        err_r <= 1'b0;
      end
    end
  end

  // Byte counter and rom_loaded; arm_r defers the flag until an in-flight write drains
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r  <= 25'd0;
      loaded_r <= 1'b0;
      arm_r    <= 1'b0;
    end else begin
      if (dl_rise_s) begin
        count_r <= (take_s && !lost_s) ? 25'd1 : 25'd0;
      end else if (take_s && !lost_s && (count_r != 25'h1FFFFFF)) begin
        count_r <= count_r + 25'd1;
      end
      if (dl_fall_s && (count_r >= ROM_SIZE)) begin
        if (quiet_s) begin
          loaded_r <= 1'b1;
        end else begin
          arm_r <= 1'b1;
        end
      end else if (arm_r && quiet_s) begin
        loaded_r <= 1'b1;
        arm_r    <= 1'b0;
      end else if (dl_rise_s) begin
        arm_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: one task per scenario, inputs driven and outputs sampled on negedge.
module tb_rom_dl_router;

  logic        clk_72 = 1'b0;
  logic        reset_n, ioctl_download, ioctl_wr, p1_ack, p2_ack;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, p1_req, p2_req, bram_wr, rom_loaded, dl_err;
  logic [22:0] p1_a, p2_a;
  logic [1:0]  p1_ds, p2_ds;
  logic [15:0] p1_d, p2_d;
  logic [16:0] bram_addr;
  logic [7:0]  bram_d;
  int total = 0;
  int bad = 0;

  always #5 clk_72 = ~clk_72;

  // Small ROM_SIZE keeps the full-image scenario short; region map is the real one
  rom_dl_router #(.ROM_SIZE(25'h0000040)) dut (
    .clk(clk_72), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a), .p1_ds(p1_ds), .p1_d(p1_d),
    .p2_req(p2_req), .p2_ack(p2_ack), .p2_a(p2_a), .p2_ds(p2_ds), .p2_d(p2_d),
    .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_d(bram_d),
    .rom_loaded(rom_loaded), .dl_err(dl_err)
  );

  function automatic logic [24:0] pick_addr(input int i);
    case (i % 4)
      0:       return 25'h0000000 + 25'(i);
      1:       return 25'h0010000 + 25'(i);
      2:       return 25'h000A000 + 25'(i);
      default: return 25'h001D000 + 25'(i);
    endcase
  endfunction

  // Send one byte and play the SDRAM side with a fixed ack delay until the router is idle
  task automatic do_byte(input logic [24:0] a, input logic [7:0] d, input int dly);
    int c1, c2, n;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_72);
    ioctl_wr = 1'b0;
    c1 = dly; c2 = dly; n = 0;
    while ((ioctl_wait || (p1_req !== p1_ack) || (p2_req !== p2_ack)) && (n < 200)) begin
      if (p1_req !== p1_ack) begin
        if (c1 == 0) p1_ack = p1_req; else c1--;
      end
      if (p2_req !== p2_ack) begin
        if (c2 == 0) p2_ack = p2_req; else c2--;
      end
      @(negedge clk_72);
      n++;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL byte_budget addr=%h cycles=%0d limit=200", a, n); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_72);
    total++;
    if ({p1_req, p2_req, ioctl_wait, bram_wr, rom_loaded, dl_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", {p1_req, p2_req, ioctl_wait, bram_wr, rom_loaded, dl_err});
    end
    total++;
    if ({p1_a, p2_a, bram_addr} !== 63'd0) begin
      bad++; $display("FAIL reset_addr got=%h/%h/%h want=0", p1_a, p2_a, bram_addr);
    end
  endtask

  task automatic test_p1();
    logic req0;
    int wcnt;
    @(negedge clk_72);
    req0 = p1_req;
    ioctl_addr = 25'h0000003; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    #1;
    wcnt = ioctl_wait ? 1 : 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_72);
      if (k == 1) begin
        ioctl_wr = 1'b0;
        total++;
        if (p1_req !== req0) begin bad++; $display("FAIL p1_req_early got=%b want=%b", p1_req, req0); end
      end
      if (k == 2) begin
        total++;
        if (p1_req !== ~req0) begin bad++; $display("FAIL p1_req_toggle got=%b want=%b", p1_req, ~req0); end
        total++;
        if (p1_a !== 23'h000001) begin bad++; $display("FAIL p1_a got=%h want=000001", p1_a); end
        total++;
        if (p1_ds !== 2'b10) begin bad++; $display("FAIL p1_ds got=%b want=10", p1_ds); end
        total++;
        if (p1_d !== 16'hA5A5) begin bad++; $display("FAIL p1_d got=%h want=a5a5", p1_d); end
      end
      if (ioctl_wait) wcnt++;
      if (k == 6) p1_ack = p1_req;
    end
    total++;
    if (wcnt != 7) begin bad++; $display("FAIL p1_wait_len got=%0d want=7", wcnt); end
  endtask

  task automatic test_p2();
    logic r1, r2;
    r1 = p1_req; r2 = p2_req;
    do_byte(25'h0010000, 8'h11, 3);
    total++;
    if ({p2_req, p2_a, p2_ds, p2_d} !== {~r2, 23'h000000, 2'b01, 16'h1111}) begin
      bad++; $display("FAIL p2_first got=%b/%h/%b/%h want=%b/000000/01/1111", p2_req, p2_a, p2_ds, p2_d, ~r2);
    end
    do_byte(25'h0014001, 8'h22, 5);
    total++;
    if ({p2_req, p2_a, p2_ds, p2_d} !== {r2, 23'h000002, 2'b10, 16'h2222}) begin
      bad++; $display("FAIL p2_second got=%b/%h/%b/%h want=%b/000002/10/2222", p2_req, p2_a, p2_ds, p2_d, r2);
    end
    total++;
    if (p1_req !== r1) begin bad++; $display("FAIL p2_no_p1 got=%b want=%b", p1_req, r1); end
  endtask

  task automatic test_bram();
    logic r1, r2;
    int pulses, at_k;
    logic [16:0] seen_a;
    logic [7:0] seen_d;
    r1 = p1_req; r2 = p2_req; pulses = 0; at_k = 0; seen_a = 17'd0; seen_d = 8'd0;
    @(negedge clk_72);
    ioctl_addr = 25'h001C31F; ioctl_dout = 8'h3C; ioctl_wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_72);
      ioctl_wr = 1'b0;
      if (bram_wr) begin pulses++; at_k = k; seen_a = bram_addr; seen_d = bram_d; end
    end
    total++;
    if ((pulses != 1) || (at_k != 2)) begin bad++; $display("FAIL bram_pulse got=%0d@%0d want=1@2", pulses, at_k); end
    total++;
    if ({seen_a, seen_d} !== {17'h1C31F, 8'h3C}) begin bad++; $display("FAIL bram_data got=%h/%h want=1c31f/3c", seen_a, seen_d); end
    total++;
    if ({p1_req, p2_req} !== {r1, r2}) begin bad++; $display("FAIL bram_no_req got=%b%b want=%b%b", p1_req, p2_req, r1, r2); end
  endtask

  task automatic test_drop();
    logic r1, r2;
    int act;
    r1 = p1_req; r2 = p2_req; act = 0;
    @(negedge clk_72);
    ioctl_addr = 25'h001C320; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_72);
      ioctl_wr = 1'b0;
      if (bram_wr || (p1_req !== r1) || (p2_req !== r2) || dl_err) act++;
      if ((k >= 2) && ioctl_wait) act++;
    end
    total++;
    if (act != 0) begin bad++; $display("FAIL drop_side_effect got=%0d want=0", act); end
  endtask

  task automatic test_timeout();
    int first_err, first_idle, pulses;
    logic [16:0] seen_a;
    first_err = 0; first_idle = 0; pulses = 0; seen_a = 17'd0;
    @(negedge clk_72);
    ioctl_addr = 25'h0000100; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk_72);
      ioctl_wr = 1'b0;
      if (dl_err && (first_err == 0)) first_err = k;
      if (!ioctl_wait && (first_idle == 0)) first_idle = k;
    end
    total++;
    if (first_err != 258) begin bad++; $display("FAIL tmo_err_cycle got=%0d want=258", first_err); end
    total++;
    if (first_idle != 258) begin bad++; $display("FAIL tmo_idle_cycle got=%0d want=258", first_idle); end
    ioctl_addr = 25'h000A000; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_72);
      ioctl_wr = 1'b0;
      if (bram_wr) begin pulses++; seen_a = bram_addr; end
    end
    total++;
    if ((pulses != 1) || (seen_a !== 17'h0A000)) begin
      bad++; $display("FAIL tmo_next_byte got=%0d/%h want=1/0a000", pulses, seen_a);
    end
    p1_ack = p1_req;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_72);
    ioctl_addr = 25'h0000002; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
    @(negedge clk_72);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_72);
    total++;
    if ((p1_req === p1_ack) || !ioctl_wait) begin
      bad++; $display("FAIL rstmid_busy got=req%b/ack%b/wait%b want=differ/1", p1_req, p1_ack, ioctl_wait);
    end
    reset_n = 1'b0;
    @(negedge clk_72);
    total++;
    if ({p1_req, p2_req, ioctl_wait, bram_wr, rom_loaded, dl_err} !== 6'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b want=000000", {p1_req, p2_req, ioctl_wait, bram_wr, rom_loaded, dl_err});
    end
    total++;
    if ({p1_a, p1_ds, p1_d} !== 41'd0) begin bad++; $display("FAIL rstmid_p1 got=%h/%b/%h want=0", p1_a, p1_ds, p1_d); end
    p1_ack = 1'b0; p2_ack = 1'b0;
    @(negedge clk_72);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_72);
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [16:0] seen_a;
    logic [7:0] seen_d;
    pulses = 0; seen_a = 17'd0; seen_d = 8'd0;
    ioctl_addr = 25'h0000010; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    @(negedge clk_72); ioctl_wr = 1'b0;
    @(negedge clk_72); ioctl_addr = 25'h000A005; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    @(negedge clk_72); ioctl_wr = 1'b0;
    total++;
    if ({p1_a, dl_err} !== {23'h000008, 1'b0}) begin bad++; $display("FAIL b2b_pend got=%h/%b want=000008/0", p1_a, dl_err); end
    @(negedge clk_72); ioctl_addr = 25'h000A006; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
    @(negedge clk_72); ioctl_wr = 1'b0;
    @(negedge clk_72);
    total++;
    if ({dl_err, ioctl_wait} !== 2'b11) begin bad++; $display("FAIL b2b_lost got=%b want=11", {dl_err, ioctl_wait}); end
    p1_ack = p1_req;
    for (int k = 7; k <= 20; k++) begin
      @(negedge clk_72);
      if (bram_wr) begin pulses++; seen_a = bram_addr; seen_d = bram_d; end
    end
    total++;
    if ((pulses != 1) || ({seen_a, seen_d} !== {17'h0A005, 8'h22})) begin
      bad++; $display("FAIL b2b_drain got=%0d/%h/%h want=1/0a005/22", pulses, seen_a, seen_d);
    end
  endtask

  task automatic test_index1();
    logic r1, r2;
    int act;
    r1 = p1_req; r2 = p2_req; act = 0;
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_72);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ioctl_addr = 25'h000A000 + 25'(i); ioctl_dout = 8'(i); ioctl_wr = 1'b1;
      @(negedge clk_72);
      if (bram_wr || ioctl_wait || (p1_req !== r1) || (p2_req !== r2)) act++;
      ioctl_wr = 1'b0;
      @(negedge clk_72);
      if (bram_wr || ioctl_wait || (p1_req !== r1) || (p2_req !== r2)) act++;
    end
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_72);
    ioctl_index = 8'd0;
    total++;
    if (act != 0) begin bad++; $display("FAIL idx1_activity got=%0d want=0", act); end
    total++;
    if (rom_loaded !== 1'b0) begin bad++; $display("FAIL idx1_loaded got=%b want=0", rom_loaded); end
  endtask

  task automatic test_short_stream();
    ioctl_download = 1'b1;
    @(negedge clk_72);
    for (int i = 0; i < 63; i++) do_byte(pick_addr(i), 8'(i), int'($urandom_range(20, 1)));
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_72);
    total++;
    if ({rom_loaded, dl_err} !== 2'b00) begin bad++; $display("FAIL short_loaded got=%b want=00", {rom_loaded, dl_err}); end
  endtask

  task automatic test_full_stream();
    ioctl_download = 1'b1;
    @(negedge clk_72);
    for (int i = 0; i < 63; i++) do_byte(pick_addr(i), 8'(i + 7), int'($urandom_range(20, 1)));
    ioctl_addr = 25'h0000020; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
    @(negedge clk_72);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_72);
    total++;
    if ({rom_loaded, ioctl_wait} !== 2'b01) begin bad++; $display("FAIL full_busy got=%b want=01", {rom_loaded, ioctl_wait}); end
    repeat (3) @(negedge clk_72);
    p1_ack = p1_req;
    repeat (5) @(negedge clk_72);
    total++;
    if ({rom_loaded, dl_err, ioctl_wait} !== 3'b100) begin
      bad++; $display("FAIL full_loaded got=%b want=100", {rom_loaded, dl_err, ioctl_wait});
    end
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; p1_ack = 1'b0; p2_ack = 1'b0;
    test_reset();
    reset_n = 1'b1; ioctl_download = 1'b1;
    repeat (2) @(negedge clk_72);
    test_p1();
    test_p2();
    test_bram();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_index1();
    test_short_stream();
    test_full_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
